// File: rtl/multdiv_stall_unit.sv
// ============================================================================
//  Module   : multdiv_stall_unit
//  Purpose  : Multi-cycle signed multiply (radix-4 Booth) / divide (restoring)
//             engine that stalls the pipeline until its result is ready.
//  Config   : MULTDIV_DIV_EN enables the divide datapath; without it every
//             divide request completes at once with exception=1, result=0.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module multdiv_stall_unit #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    input  logic [WIDTH-1:0]  operandA,
    input  logic [WIDTH-1:0]  operandB,
    input  logic [REGW-1:0]   dest_in,
    output logic              stall_from_multdiv,
    output logic              resultRDY,
    output logic [WIDTH-1:0]  result,
    output logic              exception,
    output logic [REGW-1:0]   dest_out,
    output logic              busy
);

    localparam int CNTW  = $clog2(WIDTH + 1);
    localparam int STEPS = WIDTH / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH:0]   prod_q, prod_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic [REGW-1:0]    dest_q, dest_d;

    // Booth step: add the recoded partial product into a 2-bit-wider copy of
    // the accumulator, then shift the whole product register right by two.
    logic [WIDTH+1:0]   booth_pp;
    logic [WIDTH+1:0]   booth_sum;
    logic [2*WIDTH:0]   prod_step;
    logic               mul_ovf;

    always_comb begin
        booth_pp = '0;
        case (prod_q[2:0])
            3'b001, 3'b010: booth_pp =  {{2{mcand_q[WIDTH-1]}}, mcand_q};
            3'b011:         booth_pp =  {mcand_q[WIDTH-1], mcand_q, 1'b0};
            3'b100:         booth_pp = -{mcand_q[WIDTH-1], mcand_q, 1'b0};
            3'b101, 3'b110: booth_pp = -{{2{mcand_q[WIDTH-1]}}, mcand_q};
            default:        booth_pp = '0;
        endcase
        booth_sum = {{2{prod_q[2*WIDTH]}}, prod_q[2*WIDTH:WIDTH+1]} + booth_pp;
        prod_step = {booth_sum, prod_q[WIDTH:2]};
        mul_ovf   = ~((&prod_step[2*WIDTH:WIDTH]) | ~(|prod_step[2*WIDTH:WIDTH]));
    end

`ifdef MULTDIV_DIV_EN
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               neg_q, neg_d;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    always_comb begin
        a_abs     = operandA[WIDTH-1] ? -operandA : operandA;
        b_abs     = operandB[WIDTH-1] ? -operandB : operandB;
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, dvsr_q};
        quo_fix   = neg_q ? -quo_q : quo_q;
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        result_d = result_q;
        exc_d    = exc_q;
        dest_d   = dest_q;
`ifdef MULTDIV_DIV_EN
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        neg_d    = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ctrl_MULT || ctrl_DIV) begin
                    dest_d = dest_in;
                    cnt_d  = '0;
                end
                if (ctrl_MULT && !ctrl_DIV) begin
                    mcand_d = operandA;
                    prod_d  = {{WIDTH{1'b0}}, operandB, 1'b0};
                    state_d = S_MUL;
                end
`ifdef MULTDIV_DIV_EN
                else if (ctrl_DIV && !ctrl_MULT && operandB != '0) begin
                    rem_d   = '0;
                    quo_d   = a_abs;
                    dvsr_d  = b_abs;
                    neg_d   = operandA[WIDTH-1] ^ operandB[WIDTH-1];
                    state_d = S_DIV;
                end
`endif
                else if (ctrl_MULT || ctrl_DIV) begin
                    // Divide by zero, double pulse, or divide support absent.
                    result_d = '0;
                    exc_d    = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_MUL: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(STEPS - 1)) begin
                    result_d = prod_step[WIDTH:1];
                    exc_d    = mul_ovf;
                    state_d  = S_DONE;
                end
            end
`ifdef MULTDIV_DIV_EN
            S_DIV: begin
                if (cnt_q == CNTW'(WIDTH)) begin
                    // Only most-negative / -1 yields a positive quotient with the top bit set.
                    result_d = quo_fix;
                    exc_d    = ~neg_q & quo_q[WIDTH-1];
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (!div_trial[WIDTH]) begin
                        rem_d = div_trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            dest_q   <= '0;
`ifdef MULTDIV_DIV_EN
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            dest_q   <= dest_d;
`ifdef MULTDIV_DIV_EN
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            neg_q    <= neg_d;
`endif
        end
    end

    // Gated by reset_n so a start pulse held during reset cannot raise stall.
    assign stall_from_multdiv = reset_n &
                                (((state_q == S_IDLE) & (ctrl_MULT | ctrl_DIV)) |
                                 (state_q == S_MUL) | (state_q == S_DIV));
    assign resultRDY = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign exception = exc_q;
    assign dest_out  = dest_q;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_stall_unit.sv
// ============================================================================
//  Module   : tb_multdiv_stall_unit
//  Purpose  : Self-checking bench for multdiv_stall_unit (honours MULTDIV_DIV_EN).
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multdiv_stall_unit;

    localparam int W = 32;
`ifdef MULTDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           ctrl_MULT = 1'b0;
    logic           ctrl_DIV = 1'b0;
    logic [W-1:0]   operandA = '0;
    logic [W-1:0]   operandB = '0;
    logic [4:0]     dest_in = '0;
    logic           stall_from_multdiv;
    logic           resultRDY;
    logic [W-1:0]   result;
    logic           exception;
    logic [4:0]     dest_out;
    logic           busy;

    multdiv_stall_unit #(.WIDTH(W), .REGW(5)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .ctrl_MULT          (ctrl_MULT),
        .ctrl_DIV           (ctrl_DIV),
        .operandA           (operandA),
        .operandB           (operandB),
        .dest_in            (dest_in),
        .stall_from_multdiv (stall_from_multdiv),
        .resultRDY          (resultRDY),
        .result             (result),
        .exception          (exception),
        .dest_out           (dest_out),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int rel_c    = 0;

    // Model state: one outstanding operation, its start cycle and latency.
    bit             m_active   = 1'b0;
    bit             m_chk_dest = 1'b0;
    int             m_t0       = 0;
    int             m_lat      = 0;
    logic [W-1:0]   m_res      = '0;
    logic           m_exc      = 1'b0;
    logic [4:0]     m_dest     = '0;
    logic [W-1:0]   last_res   = '0;
    logic           last_exc   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_op(input bit mul, input bit dv,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] res, output logic exc,
                                     output int lat);
        longint p;
        int     q;
        if (mul && !dv) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p[W-1:0];
            exc = (p != longint'($signed(p[W-1:0])));
            lat = W / 2 + 1;
        end else if (dv && !mul && DIV_ON && b != '0) begin
            lat = W + 2;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                res = 32'h8000_0000;
                exc = 1'b1;
            end else begin
                q   = $signed(a) / $signed(b);
                res = q;
                exc = 1'b0;
            end
        end else begin
            res = '0;
            exc = 1'b1;
            lat = 1;
        end
    endfunction

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_stall", stall_from_multdiv, 0);
            chk("rst_rdy",   resultRDY, 0);
            chk("rst_busy",  busy, 0);
            chk("rst_result", result, 0);
        end else if (m_active) begin
            rel_c = cyc - m_t0;
            chk("stall", stall_from_multdiv, rel_c < m_lat);
            chk("busy",  busy, rel_c > 0);
            chk("rdy",   resultRDY, rel_c == m_lat);
            if (rel_c >= m_lat) begin
                chk("result", result, m_res);
                chk("exception", exception, m_exc);
                if (m_chk_dest) chk("dest_out", dest_out, m_dest);
                last_res = m_res;
                last_exc = m_exc;
                m_active = 1'b0;
            end
        end else begin
            chk("idle_stall", stall_from_multdiv, 0);
            chk("idle_busy",  busy, 0);
            chk("idle_rdy",   resultRDY, 0);
            chk("hold_result", result, last_res);
            chk("hold_exc",    exception, last_exc);
        end
    end

    task automatic start_op(input bit mul, input bit dv, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [4:0] rd);
        logic [W-1:0] r;
        logic         e;
        int           l;
        @(posedge clock); #1;
        model_op(mul, dv, a, b, r, e, l);
        m_res = r; m_exc = e; m_lat = l; m_dest = rd;
        m_chk_dest = mul ^ dv;
        m_t0 = cyc;
        m_active = 1'b1;
        ctrl_MULT = mul; ctrl_DIV = dv; operandA = a; operandB = b; dest_in = rd;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        operandA = $urandom; operandB = $urandom; dest_in = '0;
    endtask

    task automatic do_op(input bit mul, input bit dv, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] rd,
                         input logic [W-1:0] lit_res, input logic lit_exc, input int lit_lat);
        int seen;
        start_op(mul, dv, a, b, rd);
        seen = -1;
        for (int i = 1; i <= 60 && seen < 0; i++) begin
            @(negedge clock);
            if (resultRDY) seen = i;
        end
        chk("lit_latency", seen, lit_lat);
        chk("lit_result", result, lit_res);
        chk("lit_exc", exception, lit_exc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("reset_stall", stall_from_multdiv, 0);
        chk("reset_result", result, 0);
        chk("reset_dest", dest_out, 0);
        chk("reset_exc", exception, 0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        do_op(1, 0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0, 17);
        do_op(1, 0, 32'h0001_0000,  32'h0001_0000, 5'd6,  32'h0000_0000, 1'b1, 17);
        do_op(1, 0, 32'h7FFF_FFFF,  32'd1,         5'd7,  32'h7FFF_FFFF, 1'b0, 17);
        do_op(1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'h0000_0001, 1'b0, 17);
        do_op(1, 0, 32'h8000_0000,  32'h8000_0000, 5'd9,  32'h0000_0000, 1'b1, 17);
        do_op(1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1, 17);
        do_op(0, 1, 32'hFFFF_FF9C,  32'd7,         5'd11,
              DIV_ON ? 32'hFFFF_FFF2 : 32'h0, DIV_ON ? 1'b0 : 1'b1, DIV_ON ? 34 : 1);
        do_op(0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12,
              DIV_ON ? 32'h8000_0000 : 32'h0, 1'b1, DIV_ON ? 34 : 1);
        do_op(0, 1, 32'd100,        32'hFFFF_FFF9, 5'd13,
              DIV_ON ? 32'hFFFF_FFF2 : 32'h0, DIV_ON ? 1'b0 : 1'b1, DIV_ON ? 34 : 1);
        do_op(0, 1, 32'd5,          32'd0,         5'd14, 32'h0, 1'b1, 1);
        do_op(1, 1, 32'd9,          32'd3,         5'd15, 32'h0, 1'b1, 1);
        do_op(0, 1, 32'd10,         32'd2,         5'd16,
              DIV_ON ? 32'd5 : 32'h0, DIV_ON ? 1'b0 : 1'b1, DIV_ON ? 34 : 1);

        // Abort a multiply in its cycle 5 with an asynchronous reset.
        start_op(1, 0, 32'h0000_1234, 32'h0000_0010, 5'd17);
        repeat (4) @(posedge clock);
        #3;
        reset_n  = 1'b0;
        m_active = 1'b0;
        last_res = '0;
        last_exc = 1'b0;
        #1;
        chk("abort_stall",  stall_from_multdiv, 0);
        chk("abort_busy",   busy, 0);
        chk("abort_result", result, 0);
        chk("abort_rdy",    resultRDY, 0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);

        do_op(1, 0, 32'd3, 32'd4, 5'd18, 32'd12, 1'b0, 17);
        do_op(1, 0, 32'd6, 32'd6, 5'd19, 32'd36, 1'b0, 17);
        repeat (3) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
